counter_share_sched: RTL and testbench

- Round-robin scheduler that time-shares one internal loadable W-bit up/down terminal-count counter among N requesters.
- Each requester asks for a timed interval of len+1 enabled ticks in a chosen direction. The scheduler grants, loads, counts on tick enable, detects terminal count, pulses that requester's done, then re-arbitrates.
- Sits between client FSMs and the shared prescaled tick in the counters library.

---
 rtl/counter_share_sched.sv | 124 ++++++++++++
 tb/tb_counter_share_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/counter_share_sched.sv
// Round-robin scheduler sharing one loadable W-bit up/down terminal-count counter
// among N requesters: grant, load, count on ce, pulse done at terminal count.
module counter_share_sched #(
    parameter int N = 4,
    parameter int W = 4,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           ce,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] len,
    input  logic [N-1:0]   dir,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic [W-1:0]   q,
    output logic           tc,
    output logic [CW-1:0]  cur,
    output logic [1:0]     dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Handshake: req is a level held by the client until done or abort;
    // gnt/done are registered and one-hot; dropping req[cur] in COUNT aborts.

    logic [1:0]    state;
    logic [CW-1:0] ptr;
    logic          cur_up;

    logic [W-1:0]  len_arr [N];
    logic          win_found;
    logic [CW-1:0] win_idx;
    logic [CW:0]   scan;
    logic [W-1:0]  win_len;
    logic [CW-1:0] ptr_next;
    logic [N-1:0]  one_n;

    assign one_n = N'(1);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            len_arr[i] = len[i*W +: W];
        end
    end

    // Scan ptr, ptr+1, ... with wrap; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 0; k < N; k++) begin
            scan = {1'b0, ptr} + (CW+1)'(k);
            if (scan >= (CW+1)'(N)) begin
                scan = scan - (CW+1)'(N);
            end
            if (!win_found && req[scan[CW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[CW-1:0];
            end
        end
    end

    assign win_len  = len_arr[win_idx];
    assign ptr_next = (win_idx == CW'(N-1)) ? '0 : win_idx + CW'(1);

    assign tc        = cur_up ? (q == {W{1'b1}}) : (q == '0);
    assign busy      = (state == S_COUNT) || (state == S_DONE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state  <= S_IDLE;
            gnt    <= '0;
            done   <= '0;
            q      <= '0;
            cur    <= '0;
            ptr    <= '0;
            cur_up <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= '0;
                    if (win_found) begin
                        state  <= S_COUNT;
                        gnt    <= one_n << win_idx;
                        cur    <= win_idx;
                        cur_up <= dir[win_idx];
                        // Up intervals start so that len+1 ticks land exactly on all-ones.
                        q      <= dir[win_idx] ? ({W{1'b1}} - win_len) : win_len;
                        ptr    <= ptr_next;
                    end
                end
                S_COUNT: begin
                    if (!req[cur]) begin
                        state <= S_IDLE;
                        gnt   <= '0;
                    end else if (ce) begin
                        if (tc) begin
                            state <= S_DONE;
                            gnt   <= '0;
                            done  <= one_n << cur;
                        end else begin
                            q <= cur_up ? q + W'(1) : q - W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    done  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_share_sched.sv
// Directed bench for counter_share_sched (N=4, W=4): vector table plus
// hand-written sequences for round-robin, abort and abort-vs-terminal-count.
module tb_counter_share_sched;

    logic        clk;
    logic        clr_n;
    logic        ce;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  dir;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  q;
    logic        tc;
    logic [1:0]  cur;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    counter_share_sched #(.N(4), .W(4)) dut (
        .clk(clk), .clr_n(clr_n), .ce(ce), .req(req), .len(len), .dir(dir),
        .gnt(gnt), .done(done), .busy(busy), .q(q), .tc(tc), .cur(cur),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr_n;
        logic [3:0]  req;
        logic        ce;
        logic [15:0] len;
        logic [3:0]  dir;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic        busy;
        logic [3:0]  q;
        logic        tc;
        logic [1:0]  cur;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(logic c, logic [3:0] r, logic e, logic [15:0] l, logic [3:0] d,
                                logic [3:0] g, logic [3:0] dn, logic b, logic [3:0] qq,
                                logic t, logic [1:0] cu);
        vec_t v;
        v.clr_n = c; v.req = r; v.ce = e; v.len = l; v.dir = d;
        v.gnt = g; v.done = dn; v.busy = b; v.q = qq; v.tc = t; v.cur = cu;
        return v;
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        clr_n = 1'b0; req = '0; ce = 1'b0; len = '0; dir = '0;
        step();
        clr_n = 1'b1;
    endtask

    // scoreboard for round-robin grant order
    logic [1:0] exp_q[$];

    int         done_cyc;
    int         last_cur;
    logic [3:0] prev_gnt;
    logic [1:0] e_cur;

    initial begin
        clr_n = 1'b0; req = '0; ce = 1'b0; len = '0; dir = '0;

        //              clr req  ce len      dir   | gnt   done  busy q  tc cur
        tbl[0]  = mk(0, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 0,  1, 0);
        // single down request, len0=3
        tbl[1]  = mk(1, 4'h1, 1, 16'h0003, 4'h0, 4'h1, 4'h0, 1, 3,  0, 0);
        tbl[2]  = mk(1, 4'h1, 1, 16'h0003, 4'h0, 4'h1, 4'h0, 1, 2,  0, 0);
        tbl[3]  = mk(1, 4'h1, 1, 16'h0003, 4'h0, 4'h1, 4'h0, 1, 1,  0, 0);
        tbl[4]  = mk(1, 4'h1, 1, 16'h0003, 4'h0, 4'h1, 4'h0, 1, 0,  1, 0);
        tbl[5]  = mk(1, 4'h1, 1, 16'h0003, 4'h0, 4'h0, 4'h1, 1, 0,  1, 0);
        tbl[6]  = mk(1, 4'h0, 1, 16'h0003, 4'h0, 4'h0, 4'h0, 0, 0,  1, 0);
        // up request on requester 1, len1=2, gated ce
        tbl[7]  = mk(1, 4'h2, 0, 16'h0020, 4'h2, 4'h2, 4'h0, 1, 13, 0, 1);
        tbl[8]  = mk(1, 4'h2, 1, 16'h0020, 4'h2, 4'h2, 4'h0, 1, 14, 0, 1);
        tbl[9]  = mk(1, 4'h2, 0, 16'h0020, 4'h2, 4'h2, 4'h0, 1, 14, 0, 1);
        tbl[10] = mk(1, 4'h2, 1, 16'h0020, 4'h2, 4'h2, 4'h0, 1, 15, 1, 1);
        tbl[11] = mk(1, 4'h2, 0, 16'h0020, 4'h2, 4'h2, 4'h0, 1, 15, 1, 1);
        tbl[12] = mk(1, 4'h2, 1, 16'h0020, 4'h2, 4'h0, 4'h2, 1, 15, 1, 1);
        tbl[13] = mk(1, 4'h0, 0, 16'h0020, 4'h2, 4'h0, 4'h0, 0, 15, 1, 1);
        // requester 2 down len 7, reset while q=5
        tbl[14] = mk(1, 4'h4, 1, 16'h0700, 4'h0, 4'h4, 4'h0, 1, 7,  0, 2);
        tbl[15] = mk(1, 4'h4, 1, 16'h0700, 4'h0, 4'h4, 4'h0, 1, 6,  0, 2);
        tbl[16] = mk(1, 4'h4, 1, 16'h0700, 4'h0, 4'h4, 4'h0, 1, 5,  0, 2);
        tbl[17] = mk(0, 4'h4, 1, 16'h0700, 4'h0, 4'h0, 4'h0, 0, 0,  1, 0);
        tbl[18] = mk(1, 4'h0, 1, 16'h0700, 4'h0, 4'h0, 4'h0, 0, 0,  1, 0);

        for (int i = 0; i < 19; i++) begin
            clr_n = tbl[i].clr_n; req = tbl[i].req; ce = tbl[i].ce;
            len = tbl[i].len; dir = tbl[i].dir;
            step();
            chk($sformatf("v%0d gnt", i),  32'(gnt),  32'(tbl[i].gnt));
            chk($sformatf("v%0d done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d q", i),    32'(q),    32'(tbl[i].q));
            chk($sformatf("v%0d tc", i),   32'(tc),   32'(tbl[i].tc));
            chk($sformatf("v%0d cur", i),  32'(cur),  32'(tbl[i].cur));
        end

        // round-robin: all requesting, len=0, ptr=0 after reset
        do_reset();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req = 4'hF; len = '0; dir = '0; ce = 1'b1;
        prev_gnt = '0; done_cyc = -1; last_cur = -1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            step();
            if (done != 4'h0) begin
                chk("rr done onehot", 32'(done), 32'(1) << last_cur);
                done_cyc = c;
            end
            if (gnt != 4'h0 && prev_gnt == 4'h0) begin
                e_cur = exp_q.pop_front();
                chk("rr cur", 32'(cur), 32'(e_cur));
                chk("rr gnt", 32'(gnt), 32'(1) << e_cur);
                if (done_cyc >= 0) chk("rr gap", 32'(c - done_cyc), 32'd2);
                last_cur = int'(e_cur);
            end
            prev_gnt = gnt;
        end
        chk("rr grants left", 32'(exp_q.size()), 32'd0);
        req = '0;
        step();

        // abort: requester 2, len 7, drop after 2 ce cycles
        do_reset();
        req = 4'h4; len = 16'h0700; dir = '0; ce = 1'b1;
        step();
        chk("ab gnt", 32'(gnt), 32'h4);
        chk("ab q load", 32'(q), 32'd7);
        step();
        step();
        chk("ab q", 32'(q), 32'd5);
        req = '0;
        step();
        chk("ab gnt clr", 32'(gnt), 32'h0);
        chk("ab done", 32'(done), 32'h0);
        chk("ab q hold", 32'(q), 32'd5);
        chk("ab busy", 32'(busy), 32'd0);
        step();
        chk("ab done2", 32'(done), 32'h0);
        chk("ab q hold2", 32'(q), 32'd5);

        // abort coinciding with ce&tc: ptr=3, requester 0 with len 0
        req = 4'h1; len = 16'h0000; dir = '0; ce = 1'b1;
        step();
        chk("at gnt", 32'(gnt), 32'h1);
        chk("at tc", 32'(tc), 32'd1);
        chk("at cur", 32'(cur), 32'd0);
        req = '0;
        step();
        chk("at gnt clr", 32'(gnt), 32'h0);
        chk("at done", 32'(done), 32'h0);
        chk("at busy", 32'(busy), 32'd0);
        step();
        chk("at done2", 32'(done), 32'h0);

        // ptr now 1: requesters 0 and 3 pending -> 3 wins
        req = 4'h9; len = 16'h2000; dir = 4'h8;
        step();
        chk("ptr gnt", 32'(gnt), 32'h8);
        chk("ptr q", 32'(q), 32'd13);
        req = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
